// File: rtl/gamma_bit_parser.sv
// Bit-serial gamma code front end: strips the zero prefix, assembles the
// code value into a 9-bit operand and hands it off with the bias operand.
module gamma_bit_parser #(
    parameter int         MAX_ZEROS = 8,
    parameter logic [7:0] BIAS      = 8'd1,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [8:0]       word_a,
    output logic [7:0]       word_b,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             err_prefix,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {ZEROS, DATA, OUT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       zcnt_q, zcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       rem_q, rem_d;
    logic [8:0]       word_a_q, word_a_d;
    logic             word_valid_q, word_valid_d;
    logic             bit_ready_q, bit_ready_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_xfer;

    assign bit_xfer = bit_valid && bit_ready_q;

    always_comb begin
        state_d      = state_q;
        zcnt_d       = zcnt_q;
        shift_d      = shift_q;
        rem_d        = rem_q;
        word_a_d     = word_a_q;
        word_valid_d = word_valid_q;
        bit_ready_d  = bit_ready_q;
        err_d        = 1'b0;
        cnt_d        = cnt_q;
        unique case (state_q)
            ZEROS: begin
                bit_ready_d = 1'b1;
                if (bit_xfer && !bit_in) begin
                    // the offending zero is dropped; the next bit starts afresh
                    if (zcnt_q == 4'(MAX_ZEROS)) begin
                        err_d  = 1'b1;
                        zcnt_d = 4'd0;
                    end else begin
                        zcnt_d = zcnt_q + 4'd1;
                    end
                end else if (bit_xfer) begin
                    shift_d = 8'd1;
                    rem_d   = zcnt_q;
                    if (zcnt_q == 4'd0) begin
                        state_d      = OUT;
                        word_a_d     = 9'd1;
                        word_valid_d = 1'b1;
                        bit_ready_d  = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_xfer) begin
                    shift_d = {shift_q[6:0], bit_in};
                    rem_d   = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d      = OUT;
                        word_a_d     = {shift_q, bit_in};
                        word_valid_d = 1'b1;
                        bit_ready_d  = 1'b0;
                    end
                end
            end
            OUT: begin
                if (word_ready) begin
                    state_d      = ZEROS;
                    word_valid_d = 1'b0;
                    bit_ready_d  = 1'b1;
                    zcnt_d       = 4'd0;
                    cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = ZEROS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ZEROS;
            zcnt_q       <= 4'd0;
            shift_q      <= 8'd0;
            rem_q        <= 4'd0;
            word_a_q     <= 9'd0;
            word_valid_q <= 1'b0;
            bit_ready_q  <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            zcnt_q       <= zcnt_d;
            shift_q      <= shift_d;
            rem_q        <= rem_d;
            word_a_q     <= word_a_d;
            word_valid_q <= word_valid_d;
            bit_ready_q  <= bit_ready_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bit_ready  = bit_ready_q;
    assign word_a     = word_a_q;
    assign word_b     = BIAS;
    assign word_valid = word_valid_q;
    assign err_prefix = err_q;
    assign word_count = cnt_q;

endmodule
